lcd_share_arb: RTL and testbench

//  Shares one lcd_ctrl byte port (rdy/val/bits) among N_REQ requesters (debug console,

---
 rtl/lcd_share_arb_pkg.sv | 13 +
 rtl/lcd_share_arb_rr_pick.sv | 35 +++
 rtl/lcd_share_arb.sv | 131 +++++++++++++
 tb/tb_lcd_share_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_share_arb_pkg.sv
// Shared LCD arbitration constants and state type.
// Included by the arbiter top; the picker does not need it.
package liblcd;

  localparam logic [7:0] LCD_CLEAR_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    XFER
  } lcd_arb_state_t;

endpackage

// File: rtl/lcd_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1,
// wrapping modulo N_REQ, so the requester at ptr itself is considered last.
module lcd_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  // One spare bit so ptr+k never overflows before the modulo correction.
  logic [IW:0] cand;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!any_o && req_i[cand[IW-1:0]]) begin
        any_o                    = 1'b1;
        idx_o                    = cand[IW-1:0];
        onehot_o[cand[IW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_share_arb.sv
// Message-granular round-robin sharing of one lcd_ctrl byte port, with optional
// clear-on-owner-change and a watchdog that aborts messages stalled by their owner.
module lcd_share_arb
  import liblcd::*;
#(
  parameter int N_REQ           = 4,
  parameter int CLEAR_ON_SWITCH = 1,
  parameter int TIMEOUT         = 4096,
  localparam int IW             = $clog2(N_REQ),
  localparam int WW             = $clog2(TIMEOUT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_val_i,
  input  logic [8*N_REQ-1:0] req_bits_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_rdy_o,
  input  logic               lcd_rdy_i,
  output logic               lcd_val_o,
  output logic [7:0]         lcd_bits_o,
  output logic [IW-1:0]      grant_id_o,
  output logic               busy_o,
  output logic               abort_o
);

  lcd_arb_state_t state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  prev_q, prev_d;
  logic           owner_valid_q, owner_valid_d;
  logic [WW-1:0]  wd_q, wd_d;

  logic [7:0]       req_byte [N_REQ];
  logic [N_REQ-1:0] pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             hs;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_byte[gi]  = req_bits_i[8*gi +: 8];
      assign req_rdy_o[gi] = (state_q == XFER) && (grant_q == IW'(gi)) &&
                             lcd_rdy_i && req_val_i[gi];
    end
  endgenerate

  lcd_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req_i    (req_val_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign hs         = lcd_rdy_i && req_val_i[grant_q];
  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    prev_d        = prev_q;
    owner_valid_d = owner_valid_q;
    wd_d          = wd_q;
    lcd_val_o     = 1'b0;
    lcd_bits_o    = '0;
    abort_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          wd_d    = '0;
          if ((CLEAR_ON_SWITCH != 0) && (!owner_valid_q || !pick_onehot[prev_q])) begin
            state_d = CLEAR;
          end else begin
            state_d = XFER;
          end
        end
      end
      CLEAR: begin
        lcd_val_o  = 1'b1;
        lcd_bits_o = LCD_CLEAR_BYTE;
        if (lcd_rdy_i) begin
          state_d       = XFER;
          owner_valid_d = 1'b1;
          prev_d        = grant_q;
          wd_d          = '0;
        end
      end
      XFER: begin
        lcd_val_o  = req_val_i[grant_q];
        lcd_bits_o = req_byte[grant_q];
        // A handshake on the expiry cycle still counts as progress.
        if (hs) begin
          wd_d = '0;
          if (req_last_i[grant_q]) begin
            state_d = IDLE;
            ptr_d   = grant_q;
          end
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = grant_q;
          abort_o = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= IW'(N_REQ - 1);
      prev_q        <= '0;
      owner_valid_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      prev_q        <= prev_d;
      owner_valid_q <= owner_valid_d;
      wd_q          <= wd_d;
    end
  end

endmodule

// File: tb/tb_lcd_share_arb.sv
// Bench for lcd_share_arb: three configurations share stimulus; a message-level
// round-robin model predicts the byte stream seen by lcd_ctrl.
module tb_lcd_share_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_val, req_last;
  logic [8*N-1:0] req_bits;
  logic           lcd_rdy;

  logic [N-1:0] o_rdy   [3];
  logic         o_val   [3];
  logic [7:0]   o_bits  [3];
  logic [1:0]   o_gid   [3];
  logic         o_busy  [3];
  logic         o_abort [3];

  lcd_share_arb #(.N_REQ(N), .CLEAR_ON_SWITCH(1), .TIMEOUT(64)) u_clr (
    .clk(clk), .rst(rst), .req_val_i(req_val), .req_bits_i(req_bits), .req_last_i(req_last),
    .req_rdy_o(o_rdy[0]), .lcd_rdy_i(lcd_rdy), .lcd_val_o(o_val[0]), .lcd_bits_o(o_bits[0]),
    .grant_id_o(o_gid[0]), .busy_o(o_busy[0]), .abort_o(o_abort[0]));
  lcd_share_arb #(.N_REQ(N), .CLEAR_ON_SWITCH(0), .TIMEOUT(64)) u_noclr (
    .clk(clk), .rst(rst), .req_val_i(req_val), .req_bits_i(req_bits), .req_last_i(req_last),
    .req_rdy_o(o_rdy[1]), .lcd_rdy_i(lcd_rdy), .lcd_val_o(o_val[1]), .lcd_bits_o(o_bits[1]),
    .grant_id_o(o_gid[1]), .busy_o(o_busy[1]), .abort_o(o_abort[1]));
  lcd_share_arb #(.N_REQ(N), .CLEAR_ON_SWITCH(1), .TIMEOUT(16)) u_wdog (
    .clk(clk), .rst(rst), .req_val_i(req_val), .req_bits_i(req_bits), .req_last_i(req_last),
    .req_rdy_o(o_rdy[2]), .lcd_rdy_i(lcd_rdy), .lcd_val_o(o_val[2]), .lcd_bits_o(o_bits[2]),
    .grant_id_o(o_gid[2]), .busy_o(o_busy[2]), .abort_o(o_abort[2]));

  logic [1:0]   sel;
  logic [N-1:0] obs_rdy;
  logic         obs_val, obs_busy, obs_abort;
  logic [7:0]   obs_bits;
  logic [1:0]   obs_gid;
  always_comb begin
    obs_rdy   = o_rdy[sel];
    obs_val   = o_val[sel];
    obs_bits  = o_bits[sel];
    obs_gid   = o_gid[sel];
    obs_busy  = o_busy[sel];
    obs_abort = o_abort[sel];
  end

  // Pending requester bytes: {id[10:9], last[8], byte[7:0]}
  logic [10:0] pend[$];
  logic [7:0]  lcd_log[$];
  logic [7:0]  exp_log[$];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, gap = 0, gap_max = 20;
  int proto_err, abort_cnt, abort_cyc, last_hs3;
  logic [N-1:0] hold;
  logic stall_en, busy_after_abort;

  function automatic int head(int id);
    for (int j = 0; j < pend.size(); j++) if (int'(pend[j][10:9]) == id) return j;
    return -1;
  endfunction

  function automatic bit logs_differ();
    if (lcd_log.size() != exp_log.size()) return 1'b1;
    for (int k = 0; k < exp_log.size(); k++) if (lcd_log[k] !== exp_log[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      int h;
      h = head(i);
      if (h >= 0 && !hold[i]) begin
        req_val[i] = 1'b1; req_last[i] = pend[h][8]; req_bits[8*i +: 8] = pend[h][7:0];
      end else begin
        req_val[i] = 1'b0; req_last[i] = 1'($urandom); req_bits[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic step();
    logic hs;
    @(negedge clk);
    cyc++;
    hs = obs_val && lcd_rdy;
    if (hs) lcd_log.push_back(obs_bits);
    if ($countones(obs_rdy) > 1) proto_err++;
    if (obs_val && !obs_busy) proto_err++;
    if (abort_cyc == cyc - 1) busy_after_abort = obs_busy;
    for (int i = 0; i < N; i++) begin
      if (obs_rdy[i]) begin
        int h;
        h = head(i);
        if (!(req_val[i] && lcd_rdy) || h < 0) proto_err++;
        else begin
          pend.delete(h);
          if (stall_en && i == 3) begin hold[3] = 1'b1; last_hs3 = cyc; end
        end
      end
    end
    if (obs_abort) begin
      abort_cnt++; abort_cyc = cyc;
      for (int k = pend.size() - 1; k >= 0; k--) if (pend[k][10:9] == obs_gid) pend.delete(k);
      hold = '0;
    end
    @(posedge clk); #1;
    if (hs) gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    else if (gap > 0) gap--;
    lcd_rdy = (gap == 0);
    drive();
  endtask

  task automatic run_done(input int budget, output bit timed_out);
    int n = 0;
    while ((pend.size() != 0 || obs_busy) && n < budget) begin step(); n++; end
    timed_out = (n >= budget);
  endtask

  task automatic do_reset();
    rst = 1'b1; pend.delete(); hold = '0; stall_en = 1'b0;
    drive(); lcd_rdy = 1'b1; gap = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lcd_log.delete(); exp_log.delete();
    proto_err = 0; abort_cnt = 0; abort_cyc = -10; last_hs3 = -100; busy_after_abort = 1'b1;
  endtask

  task automatic push_byte(int id, logic last, logic [7:0] b);
    pend.push_back({2'(id), last, b});
  endtask

  task automatic push_msg(int id, int len, bit allow_ff);
    for (int b = 0; b < len; b++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (allow_ff && $urandom_range(0, 7) == 0) v = 8'hFF;
      push_byte(id, (b == len - 1), v);
    end
  endtask

  // Message-level reference: whole messages granted round-robin, clear on owner change.
  task automatic build_expected(bit cos);
    logic [10:0] q[$];
    int ptr, owner, w;
    bit done;
    q = pend; exp_log.delete(); ptr = N - 1; owner = -1;
    while (q.size() > 0) begin
      w = -1;
      for (int k = 1; k <= N && w < 0; k++) begin
        int c;
        c = (ptr + k) % N;
        foreach (q[j]) if (int'(q[j][10:9]) == c) w = c;
      end
      if (cos && owner != w) exp_log.push_back(8'hFF);
      done = 1'b0;
      while (!done) begin
        for (int j = 0; j < q.size(); j++) begin
          if (int'(q[j][10:9]) == w) begin
            exp_log.push_back(q[j][7:0]); done = q[j][8]; q.delete(j); break;
          end
        end
      end
      owner = w; ptr = w;
    end
  endtask

  task automatic test_reset();
    sel = 0; do_reset();
    @(negedge clk);
    n_cmp++; if (obs_val !== 1'b0) begin n_bad++; $display("FAIL reset_val: got %b required 0", obs_val); end
    n_cmp++; if (obs_bits !== 8'h00) begin n_bad++; $display("FAIL reset_bits: got %h required 00", obs_bits); end
    n_cmp++; if (obs_rdy !== '0) begin n_bad++; $display("FAIL reset_rdy: got %b required 0000", obs_rdy); end
    n_cmp++; if (obs_gid !== 2'd0) begin n_bad++; $display("FAIL reset_gid: got %0d required 0", obs_gid); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", obs_busy); end
    n_cmp++; if (obs_abort !== 1'b0) begin n_bad++; $display("FAIL reset_abort: got %b required 0", obs_abort); end
  endtask

  task automatic test_hi();
    bit to;
    sel = 0; gap_max = 20; do_reset();
    push_byte(0, 1'b0, 8'h48); push_byte(0, 1'b1, 8'h69); drive();
    run_done(200, to);
    exp_log = '{8'hFF, 8'h48, 8'h69};
    n_cmp++; if (to) begin n_bad++; $display("FAIL hi_timeout: %0d bytes pending, required 0", pend.size()); end
    n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL hi_seq: got %p required %p", lcd_log, exp_log); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL hi_busy: got %b required 0", obs_busy); end
    n_cmp++; if (obs_gid !== 2'd0) begin n_bad++; $display("FAIL hi_gid: got %0d required 0", obs_gid); end
    n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL hi_proto: got %0d violations required 0", proto_err); end
  endtask

  task automatic test_simul();
    bit to;
    sel = 0; do_reset();
    push_msg(2, $urandom_range(1, 4), 1'b1); push_msg(0, $urandom_range(1, 4), 1'b1);
    build_expected(1'b1); drive();
    run_done(600, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL simul_timeout: %0d bytes pending, required 0", pend.size()); end
    n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL simul_seq: got %p required %p", lcd_log, exp_log); end
    n_cmp++; if (obs_gid !== 2'd2) begin n_bad++; $display("FAIL simul_gid: got %0d required 2", obs_gid); end
  endtask

  task automatic test_same_owner();
    bit to;
    sel = 0; do_reset();
    push_msg(1, $urandom_range(1, 4), 1'b0); push_msg(1, $urandom_range(1, 4), 1'b0);
    build_expected(1'b1); drive();
    run_done(600, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL same_timeout: %0d bytes pending, required 0", pend.size()); end
    n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL same_seq: got %p required %p", lcd_log, exp_log); end
    n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL same_proto: got %0d violations required 0", proto_err); end
  endtask

  task automatic test_no_clear();
    bit to;
    sel = 1; do_reset();
    for (int m = 0; m < 2; m++) begin
      push_msg(0, $urandom_range(1, 4), 1'b0); push_msg(1, $urandom_range(1, 4), 1'b0);
    end
    build_expected(1'b0); drive();
    run_done(1000, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL noclr_timeout: %0d bytes pending, required 0", pend.size()); end
    n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL noclr_seq: got %p required %p", lcd_log, exp_log); end
  endtask

  task automatic test_watchdog();
    bit to;
    int n = 0;
    sel = 2; gap_max = 0; do_reset();
    stall_en = 1'b1;
    push_msg(3, 3, 1'b0); drive();
    while (!obs_busy && n < 10) begin step(); n++; end
    push_msg(0, 2, 1'b0); drive();
    exp_log = '{8'hFF, pend[0][7:0], 8'hFF, pend[3][7:0], pend[4][7:0]};
    run_done(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL wd_timeout: %0d bytes pending, required 0", pend.size()); end
    n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL wd_seq: got %p required %p", lcd_log, exp_log); end
    n_cmp++; if (abort_cnt != 1) begin n_bad++; $display("FAIL wd_abort_count: got %0d required 1", abort_cnt); end
    n_cmp++; if (abort_cyc - last_hs3 != 16) begin n_bad++; $display("FAIL wd_abort_cycle: got %0d required 16", abort_cyc - last_hs3); end
    n_cmp++; if (busy_after_abort !== 1'b0) begin n_bad++; $display("FAIL wd_idle_after: got busy=%b required 0", busy_after_abort); end
    stall_en = 1'b0; gap_max = 20;
  endtask

  task automatic test_random();
    bit to;
    sel = 0; gap_max = 20;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        int nm;
        nm = $urandom_range(0, 2);
        if (i == r) nm = nm + 1;
        for (int m = 0; m < nm; m++) push_msg(i, $urandom_range(1, 4), 1'b1);
      end
      build_expected(1'b1); drive();
      run_done(4000, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL rand%0d_timeout: %0d bytes pending, required 0", r, pend.size()); end
      n_cmp++; if (logs_differ()) begin n_bad++; $display("FAIL rand%0d_seq: got %p required %p", r, lcd_log, exp_log); end
      n_cmp++; if (proto_err != 0) begin n_bad++; $display("FAIL rand%0d_proto: got %0d violations required 0", r, proto_err); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    sel = 0; gap_max = 20; do_reset();
    push_msg(2, 12, 1'b0); drive();
    while (lcd_log.size() < 3 && n < 400) begin step(); n++; end
    n_cmp++; if (n >= 400) begin n_bad++; $display("FAIL mid_reach: got %0d bytes required 3", lcd_log.size()); end
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (obs_val !== 1'b0) begin n_bad++; $display("FAIL mid_val: got %b required 0", obs_val); end
    n_cmp++; if (obs_rdy !== '0) begin n_bad++; $display("FAIL mid_rdy: got %b required 0000", obs_rdy); end
    n_cmp++; if (obs_gid !== 2'd0) begin n_bad++; $display("FAIL mid_gid: got %0d required 0", obs_gid); end
    n_cmp++; if (obs_busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b required 0", obs_busy); end
    @(posedge clk); #1;
    rst = 1'b0; pend.delete(); drive(); lcd_log.delete();
    repeat (10) step();
    n_cmp++; if (lcd_log.size() != 0) begin n_bad++; $display("FAIL mid_nobytes: got %0d bytes required 0", lcd_log.size()); end
  endtask

  initial begin
    sel = 0; rst = 1'b1; req_val = '0; req_last = '0; req_bits = '0; lcd_rdy = 1'b1;
    hold = '0; stall_en = 1'b0;
    test_reset();
    test_hi();
    test_simul();
    test_same_owner();
    test_no_clear();
    test_watchdog();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
